mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Arbitrates I-cache and D-cache miss requests onto one main-memory port.
//   Only one memory transaction is outstanding at a time. Each response is
//   routed back to the cache that issued the request, together with that
//   request's thread id.
//
//   Optional feature macro: MEM_ARB_TIMEOUT_EN
//     When it is defined, a WAIT-state watchdog completes a hung access with
//     data=0 and bus_error=1.
//
// Ports
//   clock, reset                      clock; synchronous active-high reset
//   dc_req_* / ic_req_*               single-cycle miss request: valid, info, thread id
//   dc_rsp_* / ic_rsp_*               single-cycle response: valid, data, thread id, bus_error
//   mem_req_valid/info/ready          request handshake toward memory
//   mem_rsp_valid/data/bus_error      response from memory
//
// Port index 0 is the D-cache and port index 1 is the I-cache.

package mem_arbiter_pkg;
  localparam int ADDR_WIDTH         = 32;
  localparam int DCACHE_LINE_WIDTH  = 64;
  localparam int THR_PER_CORE_WIDTH = 2;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]        addr;
    logic                         is_store;
    logic [DCACHE_LINE_WIDTH-1:0] data;
  } memory_request_t;
endpackage

// One-entry capture buffer for a single requester port. A pulse that
// arrives while the buffer is full is dropped, and a clear wins over a load.
module mem_arb_req_buf
  import mem_arbiter_pkg::*;
(
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          req_valid,
  input  memory_request_t               req_info,
  input  logic [THR_PER_CORE_WIDTH-1:0] req_tid,
  input  logic                          clear,
  output logic                          vld,
  output memory_request_t               info,
  output logic [THR_PER_CORE_WIDTH-1:0] tid
);
  always_ff @(posedge clock) begin
    if (reset) begin
      vld  <= 1'b0;
      info <= '0;
      tid  <= '0;
    end else if (clear) begin
      vld <= 1'b0;
    end else if (req_valid && !vld) begin
      vld  <= 1'b1;
      info <= req_info;
      tid  <= req_tid;
    end
  end
endmodule

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          dc_req_valid,
  input  memory_request_t               dc_req_info,
  input  logic [THR_PER_CORE_WIDTH-1:0] dc_req_thread_id,
  input  logic                          ic_req_valid,
  input  memory_request_t               ic_req_info,
  input  logic [THR_PER_CORE_WIDTH-1:0] ic_req_thread_id,
  output logic                          dc_rsp_valid,
  output logic [DCACHE_LINE_WIDTH-1:0]  dc_rsp_data,
  output logic [THR_PER_CORE_WIDTH-1:0] dc_rsp_thread_id,
  output logic                          dc_rsp_bus_error,
  output logic                          ic_rsp_valid,
  output logic [DCACHE_LINE_WIDTH-1:0]  ic_rsp_data,
  output logic [THR_PER_CORE_WIDTH-1:0] ic_rsp_thread_id,
  output logic                          ic_rsp_bus_error,
  output logic                          mem_req_valid,
  output memory_request_t               mem_req_info,
  input  logic                          mem_req_ready,
  input  logic                          mem_rsp_valid,
  input  logic [DCACHE_LINE_WIDTH-1:0]  mem_rsp_data,
  input  logic                          mem_rsp_bus_error
);
  localparam int NUM_PORTS = 2;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("mem_arbiter: TIMEOUT_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t state;
  logic   grant;       // port owning the current transaction
  logic   last_grant;  // port served most recently (round-robin pointer)
  logic   next_grant;
  logic   wd_fire;
  logic   done;

  logic [NUM_PORTS-1:0]                         req_vld;
  memory_request_t [NUM_PORTS-1:0]              req_info;
  logic [NUM_PORTS-1:0][THR_PER_CORE_WIDTH-1:0] req_tid;
  logic [NUM_PORTS-1:0]                         buf_clr;
  logic [NUM_PORTS-1:0]                         buf_vld;
  memory_request_t [NUM_PORTS-1:0]              buf_info;
  logic [NUM_PORTS-1:0][THR_PER_CORE_WIDTH-1:0] buf_tid;

  logic [NUM_PORTS-1:0]                         rsp_vld;
  logic [NUM_PORTS-1:0][DCACHE_LINE_WIDTH-1:0]  rsp_data;
  logic [NUM_PORTS-1:0][THR_PER_CORE_WIDTH-1:0] rsp_tid;
  logic [NUM_PORTS-1:0]                         rsp_err;

  assign req_vld  = {ic_req_valid, dc_req_valid};
  assign req_info = {ic_req_info, dc_req_info};
  assign req_tid  = {ic_req_thread_id, dc_req_thread_id};

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_buf
    mem_arb_req_buf u_buf (
      .clock     (clock),
      .reset     (reset),
      .req_valid (req_vld[i]),
      .req_info  (req_info[i]),
      .req_tid   (req_tid[i]),
      .clear     (buf_clr[i]),
      .vld       (buf_vld[i]),
      .info      (buf_info[i]),
      .tid       (buf_tid[i])
    );
  end

  // Transaction ends in WAIT on a real response or on watchdog expiry.
  assign done    = (state == S_WAIT) && (mem_rsp_valid || wd_fire);
  assign buf_clr = done ? (grant ? 2'b10 : 2'b01) : 2'b00;

  // When both ports are pending, serve the one not served last.
  assign next_grant = (&buf_vld) ? ~last_grant : buf_vld[1];

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wd_cnt;

  // The counter is 0 in the first WAIT cycle. It fires in the cycle where
  // it would reach TIMEOUT_CYCLES, so the pulse comes TIMEOUT_CYCLES cycles
  // after WAIT was entered. A real response in that same cycle still wins,
  // because done selects the memory data whenever mem_rsp_valid is set.
  assign wd_fire = (state == S_WAIT) && (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (reset)                                wd_cnt <= '0;
    else if (state == S_ISSUE && mem_req_ready) wd_cnt <= '0;
    else if (state == S_WAIT)                 wd_cnt <= wd_cnt + 1'b1;
  end
`else
  assign wd_fire = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= S_IDLE;
      grant         <= 1'b0;
      last_grant    <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_req_info  <= '0;
      rsp_vld       <= '0;
      rsp_data      <= '0;
      rsp_tid       <= '0;
      rsp_err       <= '0;
    end else begin
      rsp_vld <= '0;
      case (state)
        S_IDLE: begin
          if (|buf_vld) begin
            grant         <= next_grant;
            mem_req_valid <= 1'b1;
            mem_req_info  <= buf_info[next_grant];
            state         <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            mem_req_info  <= '0;
            state         <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (done) begin
            rsp_vld[grant]  <= 1'b1;
            rsp_data[grant] <= mem_rsp_valid ? mem_rsp_data : '0;
            rsp_err[grant]  <= mem_rsp_valid ? mem_rsp_bus_error : 1'b1;
            // Capture the thread id now, because the buffer clears on this edge.
            rsp_tid[grant]  <= buf_tid[grant];
            last_grant      <= grant;
            state           <= S_RESP;
          end
        end
        default: state <= S_IDLE;  // S_RESP: the pulse is out this cycle
      endcase
    end
  end

  assign dc_rsp_valid     = rsp_vld[0];
  assign dc_rsp_data      = rsp_data[0];
  assign dc_rsp_thread_id = rsp_tid[0];
  assign dc_rsp_bus_error = rsp_err[0];
  assign ic_rsp_valid     = rsp_vld[1];
  assign ic_rsp_data      = rsp_data[1];
  assign ic_rsp_thread_id = rsp_tid[1];
  assign ic_rsp_bus_error = rsp_err[1];
endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int TO = 8;
  localparam int LW = DCACHE_LINE_WIDTH;
  localparam int TW = THR_PER_CORE_WIDTH;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic dc_req_valid = 1'b0, ic_req_valid = 1'b0;
  memory_request_t dc_req_info = '0, ic_req_info = '0;
  logic [TW-1:0] dc_req_thread_id = '0, ic_req_thread_id = '0;
  logic dc_rsp_valid, ic_rsp_valid, dc_rsp_bus_error, ic_rsp_bus_error;
  logic [LW-1:0] dc_rsp_data, ic_rsp_data;
  logic [TW-1:0] dc_rsp_thread_id, ic_rsp_thread_id;
  logic mem_req_valid;
  memory_request_t mem_req_info;
  logic mem_req_ready = 1'b0;
  logic mem_rsp_valid = 1'b0;
  logic [LW-1:0] mem_rsp_data = '0;
  logic mem_rsp_bus_error = 1'b0;

  mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset),
    .dc_req_valid(dc_req_valid), .dc_req_info(dc_req_info), .dc_req_thread_id(dc_req_thread_id),
    .ic_req_valid(ic_req_valid), .ic_req_info(ic_req_info), .ic_req_thread_id(ic_req_thread_id),
    .dc_rsp_valid(dc_rsp_valid), .dc_rsp_data(dc_rsp_data),
    .dc_rsp_thread_id(dc_rsp_thread_id), .dc_rsp_bus_error(dc_rsp_bus_error),
    .ic_rsp_valid(ic_rsp_valid), .ic_rsp_data(ic_rsp_data),
    .ic_rsp_thread_id(ic_rsp_thread_id), .ic_rsp_bus_error(ic_rsp_bus_error),
    .mem_req_valid(mem_req_valid), .mem_req_info(mem_req_info), .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_bus_error(mem_rsp_bus_error)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_cmp = 0, n_fail = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // The model tracks which requests are pending per port, picks the owner of
  // each memory handshake by the round-robin rule, and predicts the response
  // pulse one cycle after memory answers (or after TO idle WAIT cycles).
  bit              pend [2];
  memory_request_t pinfo [2];
  logic [TW-1:0]   ptid [2];
  bit              last_g, waiting, fire_to;
  int              owner, wcnt, g;
  bit [1:0]        exp_v;
  logic [LW-1:0]   exp_d;
  logic [TW-1:0]   exp_t;
  bit              exp_e;
  bit              prev_mv, prev_hs;
  memory_request_t prev_info;
  logic [31:0]     addr_log [$];

  always @(negedge clock) begin
    if (reset) begin
      pend[0] = 0; pend[1] = 0; last_g = 0; waiting = 0; exp_v = '0;
      prev_mv = 0; prev_hs = 0; wcnt = 0;
    end else begin
      // Response pulses predicted in the previous cycle.
      chk("dc_rsp_valid", dc_rsp_valid, exp_v[0]);
      chk("ic_rsp_valid", ic_rsp_valid, exp_v[1]);
      if (exp_v[0] && dc_rsp_valid) begin
        chk("dc_rsp_data", dc_rsp_data, exp_d);
        chk("dc_rsp_thread_id", dc_rsp_thread_id, exp_t);
        chk("dc_rsp_bus_error", dc_rsp_bus_error, exp_e);
      end
      if (exp_v[1] && ic_rsp_valid) begin
        chk("ic_rsp_data", ic_rsp_data, exp_d);
        chk("ic_rsp_thread_id", ic_rsp_thread_id, exp_t);
        chk("ic_rsp_bus_error", ic_rsp_bus_error, exp_e);
      end
      exp_v = '0;
      // Capture new requests. A pulse is dropped while its port is busy.
      if (dc_req_valid && !pend[0]) begin pend[0] = 1; pinfo[0] = dc_req_info; ptid[0] = dc_req_thread_id; end
      if (ic_req_valid && !pend[1]) begin pend[1] = 1; pinfo[1] = ic_req_info; ptid[1] = ic_req_thread_id; end
      // Waiting for memory.
      if (waiting) begin
        wcnt++;
        fire_to = 0;
`ifdef MEM_ARB_TIMEOUT_EN
        fire_to = !mem_rsp_valid && (wcnt == TO);
`endif
        if (mem_rsp_valid || fire_to) begin
          exp_v[owner] = 1;
          exp_d = mem_rsp_valid ? mem_rsp_data : '0;
          exp_e = mem_rsp_valid ? mem_rsp_bus_error : 1'b1;
          exp_t = ptid[owner];
          pend[owner] = 0;
          last_g = owner[0];
          waiting = 0;
        end
      end
      // Memory request side.
      if (mem_req_valid) begin
        if (!pend[0] && !pend[1]) chk("mem_req_unexpected", mem_req_valid, 1'b0);
        if (prev_mv && !prev_hs) chk("mem_req_info_stable", mem_req_info, prev_info);
      end
      if (mem_req_valid && mem_req_ready) begin
        g = (pend[0] && pend[1]) ? int'(!last_g) : int'(pend[1]);
        chk("mem_req_info", mem_req_info, pinfo[g]);
        addr_log.push_back(mem_req_info.addr);
        owner = g; waiting = 1; wcnt = 0;
      end
      prev_mv = mem_req_valid;
      prev_hs = mem_req_valid && mem_req_ready;
      prev_info = mem_req_info;
    end
  end

  // ---------------- stimulus helpers ----------------
  int mreq_cyc;

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic set_dc(input logic [31:0] a, input bit st, input logic [LW-1:0] d, input logic [TW-1:0] t);
    dc_req_valid = 1; dc_req_info = '{addr: a, is_store: st, data: d}; dc_req_thread_id = t;
  endtask

  task automatic set_ic(input logic [31:0] a, input logic [TW-1:0] t);
    ic_req_valid = 1; ic_req_info = '{addr: a, is_store: 1'b0, data: '0}; ic_req_thread_id = t;
  endtask

  task automatic end_pulse();
    tick();
    dc_req_valid = 0; ic_req_valid = 0;
  endtask

  // Returns at the falling edge of the first cycle where mem_req_valid is seen.
  task automatic wait_mreq();
    bit ok;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clock);
      ok = mem_req_valid;
    end
    mreq_cyc = cyc;
    chk("mem_req_seen", ok, 1'b1);
  endtask

  // With mem_req_ready=1, answer dly cycles after WAIT is entered. Returns
  // in the cycle where the response pulse should be visible.
  task automatic serve(input int dly, input logic [LW-1:0] d, input bit e);
    wait_mreq();
    tick();
    repeat (dly) tick();
    mem_rsp_valid = 1; mem_rsp_data = d; mem_rsp_bus_error = e;
    tick();
    mem_rsp_valid = 0; mem_rsp_data = '0; mem_rsp_bus_error = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_req_valid"}, mem_req_valid, 1'b0);
    chk({tag, "_mem_req_info"}, mem_req_info, '0);
    chk({tag, "_rsp_valids"}, {dc_rsp_valid, ic_rsp_valid}, 2'b00);
    chk({tag, "_rsp_errs"}, {dc_rsp_bus_error, ic_rsp_bus_error}, 2'b00);
    chk({tag, "_rsp_data"}, {dc_rsp_data, ic_rsp_data}, '0);
    chk({tag, "_rsp_tids"}, {dc_rsp_thread_id, ic_rsp_thread_id}, '0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    int n0, base, p0;
    bit ok;

    repeat (2) tick();
    chk_all_zero("reset");
    reset = 0;
    mem_req_ready = 1;
    tick();

    // Single D-cache load with a 5-cycle memory delay.
    set_dc(32'h1000, 0, '0, 2'd1);
    end_pulse();
    serve(5, 64'hABCD_0123_4567_89EF, 0);
    chk("t1_dc_rsp_valid", dc_rsp_valid, 1'b1);
    chk("t1_dc_rsp_data", dc_rsp_data, 64'hABCD_0123_4567_89EF);
    chk("t1_dc_rsp_tid", dc_rsp_thread_id, 2'd1);
    chk("t1_dc_rsp_err", dc_rsp_bus_error, 1'b0);
    chk("t1_ic_rsp_valid", ic_rsp_valid, 1'b0);
    tick();

    // Minimum latency with zero-wait memory: mem_req at N+2, response at N+4.
    set_dc(32'h1040, 0, '0, 2'd2);
    n0 = cyc;
    end_pulse();
    serve(0, 64'h1111_2222_3333_4444, 0);
    chk("lat_mem_req", mreq_cyc - n0, 2);
    chk("lat_rsp", cyc - n0, 4);
    chk("lat_rsp_valid", dc_rsp_valid, 1'b1);
    tick();

    // Tie from reset state (last=DC): IC goes first, then DC.
    base = addr_log.size();
    set_dc(32'h2000, 0, '0, 2'd2);
    set_ic(32'h3000, 2'd3);
    end_pulse();
    serve(1, 64'h3030_3030_3030_3030, 0);
    chk("tie_ic_rsp_valid", ic_rsp_valid, 1'b1);
    chk("tie_ic_tid", ic_rsp_thread_id, 2'd3);
    p0 = cyc;
    serve(2, 64'h2020_2020_2020_2020, 0);
    chk("tie_next_issue", mreq_cyc - p0, 2);
    chk("tie_dc_rsp_valid", dc_rsp_valid, 1'b1);
    chk("tie_dc_tid", dc_rsp_thread_id, 2'd2);
    chk("tie_order0", addr_log[base], 32'h3000);
    chk("tie_order1", addr_log[base+1], 32'h2000);
    tick();

    // Serve IC alone, then tie again: DC wins this time.
    set_ic(32'h3100, 2'd0);
    end_pulse();
    serve(0, 64'h3131, 0);
    tick();
    base = addr_log.size();
    set_dc(32'h2200, 0, '0, 2'd1);
    set_ic(32'h3200, 2'd2);
    end_pulse();
    serve(0, 64'h2222, 0);
    chk("rr_dc_rsp_valid", dc_rsp_valid, 1'b1);
    serve(0, 64'h3232, 0);
    chk("rr_ic_rsp_valid", ic_rsp_valid, 1'b1);
    chk("rr_order0", addr_log[base], 32'h2200);
    chk("rr_order1", addr_log[base+1], 32'h3200);
    tick();

    // Ready held low for 7 cycles. A response during ISSUE is ignored.
    mem_req_ready = 0;
    set_ic(32'h6000, 2'd1);
    end_pulse();
    wait_mreq();
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("stall_mem_req_valid", mem_req_valid, 1'b1);
      chk("stall_mem_req_addr", mem_req_info.addr, 32'h6000);
      mem_rsp_valid = (i == 2);
    end
    mem_rsp_valid = 0;
    mem_req_ready = 1;
    tick();
    chk("stall_after_hs", mem_req_valid, 1'b0);
    mem_rsp_valid = 1; mem_rsp_data = 64'h6666;
    tick();
    mem_rsp_valid = 0; mem_rsp_data = '0;
    chk("stall_ic_rsp_valid", ic_rsp_valid, 1'b1);
    chk("stall_ic_rsp_data", ic_rsp_data, 64'h6666);
    tick();

    // Bus error on a DC store, then a normal load.
    set_dc(32'h4000, 1, 64'h5555_AAAA_5555_AAAA, 2'd0);
    end_pulse();
    serve(1, 64'h5555_AAAA_5555_AAAA, 1);
    chk("err_dc_rsp_valid", dc_rsp_valid, 1'b1);
    chk("err_dc_bus_error", dc_rsp_bus_error, 1'b1);
    tick();
    set_dc(32'h4040, 0, '0, 2'd3);
    end_pulse();
    serve(0, 64'h0404_0404, 0);
    chk("after_err_valid", dc_rsp_valid, 1'b1);
    chk("after_err_bus_error", dc_rsp_bus_error, 1'b0);

    // IC request in the same cycle as the DC response pulse.
    tick();
    set_dc(32'h7000, 0, '0, 2'd1);
    end_pulse();
    serve(0, 64'h7070, 0);
    chk("same_cyc_dc_pulse", dc_rsp_valid, 1'b1);
    set_ic(32'h7100, 2'd2);
    end_pulse();
    serve(0, 64'h7171, 0);
    chk("same_cyc_ic_pulse", ic_rsp_valid, 1'b1);
    chk("same_cyc_ic_addr", addr_log[addr_log.size()-1], 32'h7100);
    tick();

    // A second pulse while the DC buffer is full is dropped.
    set_dc(32'h5000, 0, '0, 2'd3);
    end_pulse();
    set_dc(32'h5100, 0, '0, 2'd0);
    end_pulse();
    serve(0, 64'h5050, 0);
    chk("drop_tid", dc_rsp_thread_id, 2'd3);
    chk("drop_addr", addr_log[addr_log.size()-1], 32'h5000);
    repeat (6) tick();

    // Memory never answers.
    set_dc(32'h8000, 0, '0, 2'd2);
    end_pulse();
    wait_mreq();
    tick();
    n0 = cyc;
`ifdef MEM_ARB_TIMEOUT_EN
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      ok = dc_rsp_valid;
    end
    chk("to_pulse_seen", ok, 1'b1);
    chk("to_latency", cyc - n0, TO);
    chk("to_data", dc_rsp_data, '0);
    chk("to_bus_error", dc_rsp_bus_error, 1'b1);
    tick();
    mem_rsp_valid = 1; mem_rsp_data = 64'hBAD;
    tick();
    mem_rsp_valid = 0; mem_rsp_data = '0;
    repeat (3) tick();
    chk("to_late_ignored", dc_rsp_valid, 1'b0);
`else
    repeat (20) tick();
    chk("no_wd_still_waiting", dc_rsp_valid, 1'b0);
    mem_rsp_valid = 1; mem_rsp_data = 64'h8888;
    tick();
    mem_rsp_valid = 0; mem_rsp_data = '0;
    chk("no_wd_rsp_valid", dc_rsp_valid, 1'b1);
    chk("no_wd_rsp_data", dc_rsp_data, 64'h8888);
    tick();
`endif

    // Reset while in WAIT, then a late memory response, then a fresh request.
    set_dc(32'h9000, 0, '0, 2'd1);
    end_pulse();
    wait_mreq();
    repeat (2) tick();
    reset = 1;
    tick();
    chk_all_zero("midreset");
    reset = 0;
    mem_rsp_valid = 1; mem_rsp_data = 64'h9999;
    tick();
    mem_rsp_valid = 0; mem_rsp_data = '0;
    repeat (3) tick();
    chk("midreset_late_ignored", dc_rsp_valid, 1'b0);
    set_dc(32'h9100, 0, '0, 2'd3);
    end_pulse();
    serve(0, 64'h9191, 0);
    chk("post_reset_valid", dc_rsp_valid, 1'b1);
    chk("post_reset_data", dc_rsp_data, 64'h9191);
    chk("post_reset_tid", dc_rsp_thread_id, 2'd3);

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
